// File: rtl/fabric_pkg.sv
// Shared constants for the fabric unit: config opcodes, LUT select codes and
// the config parser state encoding.
package fabric_pkg;

  localparam logic [3:0] OP_WRITE   = 4'h1;
  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_MASK    = 8'h20;
  localparam logic [7:0] OP_COMMIT  = 8'h30;
  localparam logic [7:0] OP_CLR_ERR = 8'h40;

  localparam logic [1:0] SEL_X = 2'd0;
  localparam logic [1:0] SEL_Y = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_ADDR,
    ST_W_DATA,
    ST_M_DATA,
    ST_COMMIT
  } cfg_state_e;

endpackage

// File: rtl/fabric_layer.sv
// One logic layer: per-lane 3-input LUT pair with shadow and active copies.
// Shadow entries are written by the parser; commit_i copies them to active.
module fabric_layer
  import fabric_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_sel_i,
  input  logic [5:0]       wr_lane_i,
  input  logic [7:0]       wr_data_i,
  input  logic             commit_i,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o
);

  logic [7:0] lut_x_sh_q  [WIDTH];
  logic [7:0] lut_y_sh_q  [WIDTH];
  logic [7:0] lut_x_act_q [WIDTH];
  logic [7:0] lut_y_act_q [WIDTH];

  // NOTE: the LUTs are plain flops, not RAM, so they can and must be cleared
  // by reset; a RAM macro would need an explicit clearing sequence instead.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        lut_x_sh_q[i]  <= '0;
        lut_y_sh_q[i]  <= '0;
        lut_x_act_q[i] <= '0;
        lut_y_act_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (wr_en_i && wr_lane_i == 6'(i)) begin
          if (wr_sel_i == SEL_X) lut_x_sh_q[i] <= wr_data_i;
          else                   lut_y_sh_q[i] <= wr_data_i;
        end
        if (commit_i) begin
          lut_x_act_q[i] <= lut_x_sh_q[i];
          lut_y_act_q[i] <= lut_y_sh_q[i];
        end
      end
    end
  end

  // NOTE: defaults first so every path assigns the outputs and no latch forms.
  always_comb begin
    x_o = '0;
    y_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      x_o[i] = lut_x_act_q[i][{x_i[(i+1)%WIDTH], y_i[i], x_i[i]}];
      y_o[i] = lut_y_act_q[i][{x_i[(i+1)%WIDTH], y_i[i], x_i[i]}];
    end
  end

endmodule

// File: rtl/fabric_unit.sv
// Cascaded LUT fabric with byte-serial shadow config and atomic commit.
// Data and config paths run independently; only COMMIT couples them.
module fabric_unit
  import fabric_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LAYERS = 4,
  parameter int PIPE   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [7:0]       cfg_data,
  output logic             cfg_err,
  output logic             cfg_pending
);

  localparam int LAT = (PIPE != 0) ? LAYERS + 1 : 1;

  cfg_state_e       state_q;
  logic [3:0]       layer_q;
  logic [1:0]       sel_q;
  logic [5:0]       lane_q;
  logic [2:0]       mcnt_q;
  logic [WIDTH-1:0] mask_sh_q, mask_act_q;
  logic             cfg_err_q, cfg_pending_q, cfg_ready_q;

  logic accept, target_ok, wr_fire, commit, last_mask;

  assign accept    = cfg_valid && cfg_ready_q;
  assign target_ok = (sel_q == SEL_X || sel_q == SEL_Y) &&
                     ({1'b0, layer_q} < 5'(LAYERS)) &&
                     ({1'b0, lane_q} < 7'(WIDTH));
  assign wr_fire   = accept && state_q == ST_W_DATA && target_ok;
  assign commit    = state_q == ST_COMMIT;
  assign last_mask = mcnt_q == 3'(WIDTH/8 - 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      layer_q       <= '0;
      sel_q         <= '0;
      lane_q        <= '0;
      mcnt_q        <= '0;
      mask_sh_q     <= '0;
      mask_act_q    <= '0;
      cfg_err_q     <= 1'b0;
      cfg_pending_q <= 1'b0;
      cfg_ready_q   <= 1'b1;
    end else if (commit) begin
      mask_act_q    <= mask_sh_q;
      cfg_pending_q <= 1'b0;
      cfg_ready_q   <= 1'b1;
      state_q       <= ST_IDLE;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_data[7:4] == OP_WRITE) begin
            layer_q <= cfg_data[3:0];
            state_q <= ST_W_ADDR;
          end else if (cfg_data == OP_MASK) begin
            mcnt_q  <= '0;
            state_q <= ST_M_DATA;
          end else if (cfg_data == OP_COMMIT) begin
            cfg_ready_q <= 1'b0;
            state_q     <= ST_COMMIT;
          end else if (cfg_data == OP_CLR_ERR) begin
            cfg_err_q <= 1'b0;
          end else if (cfg_data != OP_NOP) begin
            cfg_err_q <= 1'b1;
          end
        end
        ST_W_ADDR: begin
          sel_q   <= cfg_data[7:6];
          lane_q  <= cfg_data[5:0];
          state_q <= ST_W_DATA;
        end
        ST_W_DATA: begin
          if (target_ok) cfg_pending_q <= 1'b1;
          else           cfg_err_q     <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_M_DATA: begin
          mask_sh_q[{mcnt_q, 3'b000} +: 8] <= cfg_data;
          if (last_mask) begin
            cfg_pending_q <= 1'b1;
            state_q       <= ST_IDLE;
          end else begin
            mcnt_q <= mcnt_q + 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready   = cfg_ready_q;
  assign cfg_err     = cfg_err_q;
  assign cfg_pending = cfg_pending_q;

  // Layer n reads x_stage/y_stage[n-1]: a register when PIPE=1, a wire otherwise.
  logic [WIDTH-1:0] lx_in [LAYERS], ly_in [LAYERS];
  logic [WIDTH-1:0] lx_out[LAYERS], ly_out[LAYERS];
  logic [WIDTH-1:0] x_stage[LAYERS], y_stage[LAYERS];

  for (genvar n = 0; n < LAYERS; n++) begin : g_layer
    if (n == 0) begin : g_first
      assign lx_in[n] = data_in;
      assign ly_in[n] = ~data_in;
    end else begin : g_next
      assign lx_in[n] = x_stage[n-1];
      assign ly_in[n] = y_stage[n-1];
    end

    fabric_layer #(.WIDTH(WIDTH)) u_layer (
      .clk       (clk),
      .rst_n     (rst_n),
      .x_i       (lx_in[n]),
      .y_i       (ly_in[n]),
      .wr_en_i   (wr_fire && layer_q == 4'(n)),
      .wr_sel_i  (sel_q),
      .wr_lane_i (lane_q),
      .wr_data_i (cfg_data),
      .commit_i  (commit),
      .x_o       (lx_out[n]),
      .y_o       (ly_out[n])
    );
  end

  if (PIPE != 0) begin : g_pipe
    always_ff @(posedge clk) begin
      for (int n = 0; n < LAYERS; n++) begin
        if (!rst_n) begin
          x_stage[n] <= '0;
          y_stage[n] <= '0;
        end else begin
          x_stage[n] <= lx_out[n];
          y_stage[n] <= ly_out[n];
        end
      end
    end
  end else begin : g_comb
    always_comb begin
      for (int n = 0; n < LAYERS; n++) begin
        x_stage[n] = lx_out[n];
        y_stage[n] = ly_out[n];
      end
    end
  end

  logic [WIDTH-1:0] data_out_q;
  logic [LAT-1:0]   vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q <= '0;
      vld_q      <= '0;
    end else begin
      data_out_q <= (x_stage[LAYERS-1] & ~mask_act_q) | (y_stage[LAYERS-1] & mask_act_q);
      vld_q[0]   <= in_valid;
      for (int k = 1; k < LAT; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = vld_q[LAT-1];

endmodule

// File: tb/tb_fabric_unit.sv
// Directed and randomized checks of fabric_unit (PIPE=0 and PIPE=1 side by side)
// against a behavioural model of the LUT cascade and config protocol.
module tb_fabric_unit;

  localparam int W = 8;
  localparam int L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, cfg_valid;
  logic [W-1:0] data_in;
  logic [7:0]   cfg_data;
  logic [W-1:0] dout0, dout1;
  logic         ov0, ov1, rdy0, rdy1, err0, err1, pend0, pend1;

  fabric_unit #(.WIDTH(W), .LAYERS(L), .PIPE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .out_valid(ov0), .data_out(dout0), .cfg_valid(cfg_valid), .cfg_ready(rdy0),
    .cfg_data(cfg_data), .cfg_err(err0), .cfg_pending(pend0)
  );

  fabric_unit #(.WIDTH(W), .LAYERS(L), .PIPE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .out_valid(ov1), .data_out(dout1), .cfg_valid(cfg_valid), .cfg_ready(rdy1),
    .cfg_data(cfg_data), .cfg_err(err1), .cfg_pending(pend1)
  );

  int checks = 0;
  int errors = 0;

  bit [7:0] sh_x [L][W], sh_y [L][W], act_x [L][W], act_y [L][W];
  bit [7:0] sh_mask, act_mask;
  bit       exp_err, exp_pend;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: evaluate the cascade lane by lane from the active tables.
  function automatic bit [7:0] model(bit [7:0] v);
    bit [7:0] x, y, nx, ny;
    int idx;
    x = v;
    y = ~v;
    for (int n = 0; n < L; n++) begin
      for (int i = 0; i < W; i++) begin
        idx   = 4 * x[(i+1)%W] + 2 * y[i] + x[i];
        nx[i] = act_x[n][i][idx];
        ny[i] = act_y[n][i][idx];
      end
      x = nx;
      y = ny;
    end
    return (x & ~act_mask) | (y & act_mask);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(bit [7:0] b);
    int guard = 0;
    while (rdy0 !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    if (guard == 10) check("cfg_ready_timeout", rdy0, 1);
    cfg_valid = 1'b1;
    cfg_data  = b;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic clear_model();
    for (int n = 0; n < L; n++)
      for (int i = 0; i < W; i++) begin
        sh_x[n][i] = '0; sh_y[n][i] = '0; act_x[n][i] = '0; act_y[n][i] = '0;
      end
    sh_mask  = '0;
    act_mask = '0;
    exp_err  = 1'b0;
    exp_pend = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    clear_model();
  endtask

  task automatic cfg_write(int layer, int sel, int lane, bit [7:0] d);
    send(8'h10 | 8'(layer));
    send(8'((sel << 6) | lane));
    send(d);
    if (sel < 2 && layer < L && lane < W) begin
      if (sel == 0) sh_x[layer][lane] = d;
      else          sh_y[layer][lane] = d;
      exp_pend = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic cfg_mask(bit [7:0] m);
    send(8'h20);
    send(m);
    sh_mask  = m;
    exp_pend = 1'b1;
  endtask

  task automatic cfg_commit();
    send(8'h30);
    check("commit_ready_low", rdy0, 0);
    step();
    act_x    = sh_x;
    act_y    = sh_y;
    act_mask = sh_mask;
    exp_pend = 1'b0;
    check("commit_ready_back", rdy0, 1);
    check("commit_pending_clr", pend0, 0);
  endtask

  task automatic data_check0(string tag, bit [7:0] v);
    data_in = v;
    step();
    check(tag, dout0, model(v));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit [7:0] hd[$];
    bit       hv[$];

    cfg_data = '0;
    data_in  = '0;
    do_reset();

    // Reset state
    check("rst_dout0", dout0, 0);
    check("rst_ov0", ov0, 0);
    check("rst_ready", rdy0, 1);
    check("rst_err", err0, 0);
    check("rst_pending", pend0, 0);
    check("rst_dout1", dout1, 0);
    check("rst_ov1", ov1, 0);
    check("rst_ready1", rdy1, 1);
    check("rst_err1", err1, 0);
    check("rst_pending1", pend1, 0);

    // Identity LUT_X in shadow only, then commit
    for (int n = 0; n < L; n++)
      for (int i = 0; i < W; i++) cfg_write(n, 0, i, 8'hAA);
    cfg_mask(8'h00);
    data_check0("shadow_isolated", 8'h5A);
    check("shadow_isolated_zero", dout0, 8'h00);
    check("pending_set", pend0, 1);
    cfg_commit();
    data_check0("identity", 8'h5A);
    check("identity_value", dout0, 8'h5A);

    // Layer 3 LUT_Y all ones, upper nibble selects y
    for (int i = 0; i < W; i++) cfg_write(3, 1, i, 8'hFF);
    cfg_mask(8'hF0);
    cfg_commit();
    data_check0("mask_select", 8'h5A);
    check("mask_select_value", dout0, 8'hFA);

    // Out-of-range and malformed commands
    cfg_write(5, 0, 0, 8'h11);
    step();
    check("bad_layer_err", err0, exp_err);
    check("bad_layer_dout", dout0, model(8'h5A));
    check("bad_layer_pending", pend0, exp_pend);
    send(8'h40);
    exp_err = 1'b0;
    check("clr_err", err0, 0);
    cfg_write(0, 2, 0, 8'h00);
    check("bad_sel_err", err0, 1);
    send(8'h40);
    cfg_write(1, 0, 9, 8'h00);
    check("bad_lane_err", err0, 1);
    check("bad_lane_pending", pend0, 0);
    send(8'h40);
    send(8'h77);
    check("bad_opcode_err", err0, 1);
    send(8'h00);
    check("nop_keeps_err", err0, 1);
    send(8'h40);
    exp_err = 1'b0;
    check("clr_err2", err0, 0);

    // Back to identity, then pipelined latency
    for (int i = 0; i < W; i++) cfg_write(3, 1, i, 8'h00);
    cfg_mask(8'h00);
    cfg_commit();
    data_in = 8'h00;
    for (int k = 0; k < 6; k++) step();
    in_valid = 1'b1;
    data_in  = 8'h3C;
    step();
    in_valid = 1'b0;
    data_in  = 8'h00;
    check("p0_valid", ov0, 1);
    check("p0_data", dout0, 8'h3C);
    check("p1_early_valid", ov1, 0);
    for (int k = 2; k <= 5; k++) begin
      step();
      if (k < 5) check("p1_early_valid", ov1, 0);
    end
    check("p1_valid", ov1, 1);
    check("p1_data", dout1, 8'h3C);
    check("p0_valid_drop", ov0, 0);

    // Reset mid-command: next byte is a header
    send(8'h10);
    send(8'h00);
    do_reset();
    check("post_rst_ready", rdy0, 1);
    send(8'h30);
    check("rst_commit_ready_low", rdy0, 0);
    check("rst_commit_no_err", err0, 0);
    step();
    check("rst_commit_ready_back", rdy0, 1);
    check("rst_commit_pending", pend0, 0);
    data_check0("rst_cleared_luts", 8'hA5);

    // Randomized config rounds with streaming data
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 12; w++)
        cfg_write($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 8), 8'($urandom));
      cfg_mask(8'($urandom));
      check("rnd_err", err0, exp_err);
      check("rnd_pending", pend0, exp_pend);
      data_check0("rnd_shadow_isolated", 8'($urandom));
      send(8'h40);
      exp_err = 1'b0;
      cfg_commit();
      hd.delete();
      hv.delete();
      for (int k = 0; k < 24; k++) begin
        in_valid = 1'($urandom);
        data_in  = 8'($urandom);
        step();
        check("rnd_dout0", dout0, model(data_in));
        check("rnd_ov0", ov0, in_valid);
        hd.push_back(data_in);
        hv.push_back(in_valid);
        if (k >= 4) begin
          check("rnd_dout1", dout1, model(hd[k-4]));
          check("rnd_ov1", ov1, hv[k-4]);
        end
      end
      in_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fabric_unit.md
FABRIC_UNIT -- requirements
Module: fabric_unit

Interface
REQ-001 Parameter WIDTH, default 8: lanes per layer, 8..64, multiple of 8.
REQ-002 Parameter LAYERS, default 4: cascaded logic layers, 1..16.
REQ-003 Parameter PIPE, default 0: 1 inserts a register after every layer.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  data_in qualifier.
REQ-007 data_in  input  WIDTH  operand word.
REQ-008 out_valid  output  1  data_out qualifier.
REQ-009 data_out  output  WIDTH  result word, registered.
REQ-010 cfg_valid  input  1  config byte offered.
REQ-011 cfg_ready  output  1  config byte accepted when cfg_valid & cfg_ready.
REQ-012 cfg_data  input  8  config byte.
REQ-013 cfg_err  output  1  sticky config error flag.
REQ-014 cfg_pending  output  1  shadow config written since last commit.

Function
REQ-015 Lane i of each layer SHALL compute idx = {x[(i+1)%WIDTH], y[i], x[i]}; out_x[i] = LUT_X[i][idx], out_y[i] = LUT_Y[i][idx]; each LUT is 8 bits.
REQ-016 Layer 0 inputs SHALL be x = data_in, y = ~data_in; layer n inputs SHALL be layer n-1 outputs.
REQ-017 Result SHALL be (x_last & ~mask) | (y_last & mask), mask = active WIDTH-bit output-select register.
REQ-018 Latency SHALL be 1 cycle (PIPE=0) or LAYERS+1 cycles (PIPE=1); out_valid SHALL be in_valid delayed by the same latency; data_out SHALL update every cycle regardless of in_valid.
REQ-019 Config parser states: IDLE, W_ADDR, W_DATA, M_DATA, COMMIT.
REQ-020 IDLE byte [7:4]=0x1: WRITE header, [3:0]=layer -> W_ADDR; address byte [7:6]=sel, [5:0]=lane -> W_DATA; data byte written to shadow LUT -> IDLE.
REQ-021 sel 0 = LUT_X, sel 1 = LUT_Y; sel 2/3, layer>=LAYERS or lane>=WIDTH SHALL drop the write and set cfg_err.
REQ-022 IDLE byte 0x20: MASK -> M_DATA; next WIDTH/8 bytes load shadow mask LSB-first -> IDLE.
REQ-023 IDLE byte 0x30: COMMIT -> COMMIT state for one cycle; cfg_ready SHALL be 0 in that cycle; all shadow LUTs and mask copy to active at its end; cfg_pending clears.
REQ-024 IDLE byte 0x40 SHALL clear cfg_err; 0x00 is NOP; any other IDLE byte SHALL set cfg_err and stay IDLE.
REQ-025 cfg_ready SHALL be 1 in every state except COMMIT; a byte is consumed only on cfg_valid & cfg_ready; cfg_valid low mid-command SHALL hold state.
REQ-026 Datapath SHALL use active config only; shadow writes SHALL never affect data_out before COMMIT.
REQ-027 Data in flight at commit (PIPE=1) SHALL use new active config for layers evaluated after commit; no stall.
REQ-028 cfg_pending SHALL set on any accepted (non-dropped) WRITE data byte or final MASK byte.
REQ-029 Config and data traffic SHALL proceed concurrently with no interaction except REQ-023/027.

Reset
REQ-030 rst_n low SHALL clear shadow and active LUTs, masks, pipeline registers, data_out, out_valid, cfg_err, cfg_pending; parser to IDLE.
REQ-031 Reset mid-command SHALL discard the partial command; first byte after reset parses as header.
REQ-032 cfg_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-033 Package fabric_pkg SHALL hold opcodes (0x1,0x20,0x30,0x40), sel codes and the parser state enum.
REQ-034 Sub-module fabric_layer (WIDTH param) SHALL hold one layer's shadow/active LUTs and lane logic; instantiated LAYERS times via generate.
REQ-035 Optional PIPE registers and out_valid delay line SHALL live in fabric_unit.

Verification
REQ-036 Reset, WIDTH=8, LAYERS=4, PIPE=0 -> data_out 0x00, out_valid 0, cfg_ready 1, cfg_err 0, cfg_pending 0.
REQ-037 Write LUT_X=0xAA all lanes all layers, mask 0x00, no commit, data_in 0x5A -> data_out 0x00, cfg_pending 1; after COMMIT -> data_out 0x5A one cycle after input, cfg_pending 0.
REQ-038 Then write layer3 LUT_Y=0xFF all lanes, mask 0xF0, COMMIT, data_in 0x5A -> data_out 0xFA.
REQ-039 WRITE header 0x15 (layer 5) + addr + data -> cfg_err 1, data_out unchanged, cfg_pending unchanged; byte 0x40 -> cfg_err 0.
REQ-040 PIPE=1, identity config from REQ-037, in_valid pulse with 0x3C -> out_valid and data_out 0x3C exactly 5 cycles later.
REQ-041 Send 0x10, 0x00, reset, release, then 0x30 -> COMMIT executes (cfg_ready low one cycle), no LUT written.
